ntt_butterfly_pe: RTL and testbench



---
 rtl/ntt_butterfly_pe.sv | 204 ++++++++++++++++++++
 tb/tb_ntt_butterfly_pe.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ntt_butterfly_pe.sv
// ntt_butterfly_pe: fully pipelined Cooley-Tukey / Gentleman-Sande NTT butterfly
// with an internal twiddle sequencer (start delay, per-twiddle repeat count).
//
// Valid handshake: a sample is accepted on every rising edge where in_valid=1.
// There is no ready and the pipeline never stalls. out_valid=1 means x_out/y_out
// carry the result of the sample accepted LAT = MULT_LAT+2 edges earlier. While
// out_valid=0 the outputs hold their last value.
module ntt_butterfly_pe #(
  parameter int                         W        = 28,
  parameter logic [W-1:0]               Q        = W'(268369921),
  parameter int                         N_TW     = 8,
  parameter logic [N_TW-1:0][W-1:0]     TW_INIT  = {N_TW{W'(1)}},
  parameter int                         START    = 6,
  parameter int                         REPEAT   = 1,
  parameter int                         MULT_LAT = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         restart,
  input  logic         in_valid,
  input  logic         mode,
  input  logic [W-1:0] x_in,
  input  logic [W-1:0] y_in,
  output logic         out_valid,
  output logic [W-1:0] x_out,
  output logic [W-1:0] y_out
);

  localparam int PW = $clog2(START + 2);
  localparam int IW = (N_TW > 1) ? $clog2(N_TW) : 1;
  localparam int RW = (REPEAT > 1) ? $clog2(REPEAT) : 1;
  localparam logic [PW-1:0]  START_C  = PW'(START);
  localparam logic [IW-1:0]  IDX_LAST = IW'(N_TW - 1);
  localparam logic [RW-1:0]  REP_LAST = RW'(REPEAT - 1);
  localparam logic [2*W-1:0] Q2       = {{W{1'b0}}, Q};

  // Operands are assumed < Q, so one conditional correction suffices.
  function automatic logic [W-1:0] mod_add(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, Q}) s = s - {1'b0, Q};
    return s[W-1:0];
  endfunction

  // The borrow bit of the (W+1)-bit difference flags a negative result.
  function automatic logic [W-1:0] mod_sub(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] d;
    d = {1'b0, a} - {1'b0, b};
    if (d[W]) d = d + {1'b0, Q};
    return d[W-1:0];
  endfunction

  // ---------------- twiddle sequencer ----------------
  logic [PW-1:0] pre_q, pre_d, pre_b;
  logic [IW-1:0] idx_q, idx_d, idx_b, sel_idx;
  logic [RW-1:0] rep_q, rep_d, rep_b;

  // Next sequencer state; restart wipes the state before the current sample is counted.
  always_comb begin
    pre_b   = restart ? '0 : pre_q;
    idx_b   = restart ? '0 : idx_q;
    rep_b   = restart ? '0 : rep_q;
    pre_d   = pre_b;
    idx_d   = idx_b;
    rep_d   = rep_b;
    sel_idx = '0;
    if (in_valid) begin
      if (pre_b < START_C) begin
        pre_d = pre_b + 1'b1;
      end else begin
        sel_idx = idx_b;
        if (rep_b == REP_LAST) begin
          rep_d = '0;
          idx_d = (idx_b == IDX_LAST) ? '0 : idx_b + 1'b1;
        end else begin
          rep_d = rep_b + 1'b1;
        end
      end
    end
  end

  // Sequencer state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_q <= '0;
      idx_q <= '0;
      rep_q <= '0;
    end else begin
      pre_q <= pre_d;
      idx_q <= idx_d;
      rep_q <= rep_d;
    end
  end

  // ---------------- stage 0: capture sample, mode and twiddle ----------------
  logic         s0_v_q, s0_m_q;
  logic [W-1:0] s0_x_q, s0_y_q, s0_w_q;

  // Input register; the twiddle table read is registered here with the sample.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s0_v_q <= 1'b0;
      s0_m_q <= 1'b0;
      s0_x_q <= '0;
      s0_y_q <= '0;
      s0_w_q <= '0;
    end else begin
      s0_v_q <= in_valid;
      if (in_valid) begin
        s0_m_q <= mode;
        s0_x_q <= x_in;
        s0_y_q <= y_in;
        s0_w_q <= TW_INIT[sel_idx];
      end
    end
  end

  // ---------------- stage 1: GS add/sub, CT pass-through ----------------
  // a is the value that bypasses the multiplier, b is the multiplicand.
  logic         s1_v_q, s1_m_q;
  logic [W-1:0] s1_a_q, s1_b_q, s1_w_q;

  // GS forms sum/difference before the multiply; CT forwards x and y unchanged.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_v_q <= 1'b0;
      s1_m_q <= 1'b0;
      s1_a_q <= '0;
      s1_b_q <= '0;
      s1_w_q <= '0;
    end else begin
      s1_v_q <= s0_v_q;
      if (s0_v_q) begin
        s1_m_q <= s0_m_q;
        s1_w_q <= s0_w_q;
        s1_a_q <= s0_m_q ? mod_add(s0_x_q, s0_y_q) : s0_x_q;
        s1_b_q <= s0_m_q ? mod_sub(s0_x_q, s0_y_q) : s0_y_q;
      end
    end
  end

  // ---------------- modular multiplier, MULT_LAT stages ----------------
  // The reduced product enters the first stage; the trailing stages give
  // retiming room to spread the product/reduction logic.
  logic [2*W-1:0] prod;
  logic           mv_q [MULT_LAT];
  logic           mm_q [MULT_LAT];
  logic [W-1:0]   ma_q [MULT_LAT];
  logic [W-1:0]   mr_q [MULT_LAT];

  assign prod = {{W{1'b0}}, s1_b_q} * {{W{1'b0}}, s1_w_q};

  // Multiplier pipeline; the bypass operand and mode travel alongside.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < MULT_LAT; k++) begin
        mv_q[k] <= 1'b0;
        mm_q[k] <= 1'b0;
        ma_q[k] <= '0;
        mr_q[k] <= '0;
      end
    end else begin
      mv_q[0] <= s1_v_q;
      if (s1_v_q) begin
        mm_q[0] <= s1_m_q;
        ma_q[0] <= s1_a_q;
        mr_q[0] <= W'(prod % Q2);
      end
      for (int k = 1; k < MULT_LAT; k++) begin
        mv_q[k] <= mv_q[k-1];
        if (mv_q[k-1]) begin
          mm_q[k] <= mm_q[k-1];
          ma_q[k] <= ma_q[k-1];
          mr_q[k] <= mr_q[k-1];
        end
      end
    end
  end

  // ---------------- final stage: CT add/sub, GS pass-through ----------------
  logic [W-1:0] x_d, y_d;

  // CT combines x with w*y; GS already has its sum and the product of the difference.
  always_comb begin
    x_d = mm_q[MULT_LAT-1] ? ma_q[MULT_LAT-1] : mod_add(ma_q[MULT_LAT-1], mr_q[MULT_LAT-1]);
    y_d = mm_q[MULT_LAT-1] ? mr_q[MULT_LAT-1] : mod_sub(ma_q[MULT_LAT-1], mr_q[MULT_LAT-1]);
  end

  // Output register; holds the last result while no new one arrives.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      x_out     <= '0;
      y_out     <= '0;
    end else begin
      out_valid <= mv_q[MULT_LAT-1];
      if (mv_q[MULT_LAT-1]) begin
        x_out <= x_d;
        y_out <= y_d;
      end
    end
  end

endmodule

// File: tb/tb_ntt_butterfly_pe.sv
// Bench for ntt_butterfly_pe: two instances (directed twiddle table and the
// START=2/REPEAT=2 sequencing configuration) checked by a queue scoreboard.
module tb_ntt_butterfly_pe;

  localparam int           W   = 28;
  localparam logic [W-1:0] Q   = 28'd268369921;
  localparam logic [W-1:0] QM1 = 28'd268369920;
  localparam int           LAT = 6;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic         d_restart, d_in_valid, d_mode, d_out_valid;
  logic [W-1:0] d_x, d_y, d_x_out, d_y_out;
  logic         s_restart, s_in_valid, s_mode, s_out_valid;
  logic [W-1:0] s_x, s_y, s_x_out, s_y_out;

  ntt_butterfly_pe #(
    .W(W), .Q(Q), .N_TW(3), .TW_INIT({28'd3, QM1, 28'd1}),
    .START(0), .REPEAT(1), .MULT_LAT(4)
  ) u_dir (
    .clk(clk), .rst(rst), .restart(d_restart), .in_valid(d_in_valid), .mode(d_mode),
    .x_in(d_x), .y_in(d_y), .out_valid(d_out_valid), .x_out(d_x_out), .y_out(d_y_out)
  );

  ntt_butterfly_pe #(
    .W(W), .Q(Q), .N_TW(8),
    .TW_INIT({28'd8, 28'd7, 28'd6, 28'd5, 28'd4, 28'd3, 28'd2, 28'd1}),
    .START(2), .REPEAT(2), .MULT_LAT(4)
  ) u_seq (
    .clk(clk), .rst(rst), .restart(s_restart), .in_valid(s_in_valid), .mode(s_mode),
    .x_in(s_x), .y_in(s_y), .out_valid(s_out_valid), .x_out(s_x_out), .y_out(s_y_out)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0] d_exp_x[$], d_exp_y[$], s_exp_x[$], s_exp_y[$];
  int           d_exp_t[$], s_exp_t[$];
  logic [W-1:0] d_last_x = '0, d_last_y = '0, s_last_x = '0, s_last_y = '0;
  int d_pre = 0, d_idx = 0, d_rep = 0;
  int s_pre = 0, s_idx = 0, s_rep = 0;
  logic [W-1:0] dir_tw [3] = '{28'd1, 28'd268369920, 28'd3};
  logic [W-1:0] seq_tw [8] = '{28'd1, 28'd2, 28'd3, 28'd4, 28'd5, 28'd6, 28'd7, 28'd8};
  int seq_exp [20] = '{1, 1, 1, 1, 2, 2, 3, 3, 4, 4, 5, 5, 6, 6, 7, 7, 8, 8, 1, 1};

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  task automatic seq_step(input int start, input int nrep, input int ntw, input logic rs,
                          input int pre_i, input int idx_i, input int rep_i,
                          output int sel, output int pre_o, output int idx_o, output int rep_o);
    pre_o = rs ? 0 : pre_i;
    idx_o = rs ? 0 : idx_i;
    rep_o = rs ? 0 : rep_i;
    sel   = 0;
    if (pre_o < start) pre_o++;
    else begin
      sel = idx_o;
      if (rep_o == nrep - 1) begin
        rep_o = 0;
        idx_o = (idx_o + 1) % ntw;
      end else rep_o++;
    end
  endtask

  task automatic ref_bf(input logic m, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [W-1:0] w, output logic [W-1:0] xo, output logic [W-1:0] yo);
    longint unsigned q, xl, yl, wl, t;
    q = longint'(Q); xl = longint'(x); yl = longint'(y); wl = longint'(w);
    if (!m) begin
      t  = (wl * yl) % q;
      xo = W'((xl + t) % q);
      yo = W'((xl + q - t) % q);
    end else begin
      xo = W'((xl + yl) % q);
      yo = W'((((xl + q - yl) % q) * wl) % q);
    end
  endtask

  function automatic logic [W-1:0] rnd_op();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return '0;
    if (r == 1) return QM1;
    return W'($urandom_range(268369920, 0));
  endfunction

  // ---------------- driver tasks ----------------
  // lit=1 pushes the supplied literal result instead of the model's.
  task automatic drive_dir(input logic v, input logic m, input logic [W-1:0] x, input logic [W-1:0] y,
                           input logic lit, input logic [W-1:0] ex, input logic [W-1:0] ey);
    int sel;
    logic [W-1:0] rx, ry;
    @(negedge clk);
    d_in_valid = v; d_mode = m; d_x = x; d_y = y; d_restart = 1'b0;
    if (v) begin
      seq_step(0, 1, 3, 1'b0, d_pre, d_idx, d_rep, sel, d_pre, d_idx, d_rep);
      ref_bf(m, x, y, dir_tw[sel], rx, ry);
      if (lit) begin rx = ex; ry = ey; end
      d_exp_x.push_back(rx);
      d_exp_y.push_back(ry);
      d_exp_t.push_back(cyc + 1 + LAT);
    end
  endtask

  task automatic drive_seq(input logic v, input logic rs, input logic m, input logic [W-1:0] x,
                           input logic [W-1:0] y, input logic lit, input logic [W-1:0] ex,
                           input logic [W-1:0] ey);
    int sel;
    logic [W-1:0] rx, ry;
    @(negedge clk);
    s_in_valid = v; s_restart = rs; s_mode = m; s_x = x; s_y = y;
    if (v) begin
      seq_step(2, 2, 8, rs, s_pre, s_idx, s_rep, sel, s_pre, s_idx, s_rep);
      ref_bf(m, x, y, seq_tw[sel], rx, ry);
      if (lit) begin rx = ex; ry = ey; end
      s_exp_x.push_back(rx);
      s_exp_y.push_back(ry);
      s_exp_t.push_back(cyc + 1 + LAT);
    end else if (rs) begin
      s_pre = 0; s_idx = 0; s_rep = 0;
    end
  endtask

  task automatic dir_idle();
    drive_dir(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  task automatic seq_idle();
    drive_seq(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (rst) begin
      if (d_out_valid) begin
        if (d_exp_x.size() == 0) check_eq("dir_unexpected_out", 64'(d_out_valid), 64'(0));
        else begin
          d_last_x = d_exp_x.pop_front();
          d_last_y = d_exp_y.pop_front();
          check_eq("dir_x", 64'(d_x_out), 64'(d_last_x));
          check_eq("dir_y", 64'(d_y_out), 64'(d_last_y));
          check_eq("dir_lat", 64'(cyc), 64'(d_exp_t.pop_front()));
        end
      end else begin
        check_eq("dir_hold_x", 64'(d_x_out), 64'(d_last_x));
        check_eq("dir_hold_y", 64'(d_y_out), 64'(d_last_y));
        if (d_exp_t.size() > 0 && d_exp_t[0] <= cyc) begin
          check_eq("dir_missing_out", 64'(d_out_valid), 64'(1));
          void'(d_exp_x.pop_front()); void'(d_exp_y.pop_front()); void'(d_exp_t.pop_front());
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      if (s_out_valid) begin
        if (s_exp_x.size() == 0) check_eq("seq_unexpected_out", 64'(s_out_valid), 64'(0));
        else begin
          s_last_x = s_exp_x.pop_front();
          s_last_y = s_exp_y.pop_front();
          check_eq("seq_x", 64'(s_x_out), 64'(s_last_x));
          check_eq("seq_y", 64'(s_y_out), 64'(s_last_y));
          check_eq("seq_lat", 64'(cyc), 64'(s_exp_t.pop_front()));
        end
      end else begin
        check_eq("seq_hold_x", 64'(s_x_out), 64'(s_last_x));
        check_eq("seq_hold_y", 64'(s_y_out), 64'(s_last_y));
        if (s_exp_t.size() > 0 && s_exp_t[0] <= cyc) begin
          check_eq("seq_missing_out", 64'(s_out_valid), 64'(1));
          void'(s_exp_x.pop_front()); void'(s_exp_y.pop_front()); void'(s_exp_t.pop_front());
        end
      end
    end
  end

  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      if (d_exp_t.size() == 0 && s_exp_t.size() == 0) break;
      @(negedge clk);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    d_restart = 0; d_in_valid = 0; d_mode = 0; d_x = '0; d_y = '0;
    s_restart = 0; s_in_valid = 0; s_mode = 0; s_x = '0; s_y = '0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_dir_valid", 64'(d_out_valid), 64'(0));
    check_eq("rst_dir_x", 64'(d_x_out), 64'(0));
    check_eq("rst_dir_y", 64'(d_y_out), 64'(0));
    check_eq("rst_seq_valid", 64'(s_out_valid), 64'(0));
    check_eq("rst_seq_x", 64'(s_x_out), 64'(0));
    check_eq("rst_seq_y", 64'(s_y_out), 64'(0));
    #2 rst = 1'b1;

    // Directed butterflies, back to back with mixed modes; twiddles cycle 1, Q-1, 3.
    drive_dir(1, 0, 28'd5, 28'd3, 1, 28'd8, 28'd2);
    drive_dir(1, 0, QM1, QM1, 1, 28'd0, 28'd268369919);
    drive_dir(1, 1, 28'd10, 28'd4, 1, 28'd14, 28'd18);
    drive_dir(1, 0, 28'd1, 28'd3, 1, 28'd4, 28'd268369919);
    drive_dir(1, 1, rnd_op(), rnd_op(), 0, '0, '0);
    drive_dir(1, 0, rnd_op(), rnd_op(), 0, '0, '0);
    drive_dir(1, 1, 28'd4, 28'd10, 1, 28'd14, 28'd268369915);
    for (int i = 0; i < 24; i++)
      drive_dir(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), rnd_op(), rnd_op(), 0, '0, '0);
    dir_idle();

    // Sequencing: START=2, REPEAT=2, x=0, y=1 so x_out is the twiddle itself.
    for (int i = 0; i < 20; i++) begin
      int gaps;
      gaps = $urandom_range(0, 2);
      for (int g = 0; g < gaps; g++) seq_idle();
      drive_seq(1, 0, 0, 28'd0, 28'd1, 1, W'(seq_exp[i]), Q - W'(seq_exp[i]));
    end
    seq_idle();
    drain();

    // Restart on the 7th sample of a continuous stream.
    for (int i = 0; i < 10; i++)
      drive_seq(1, 1'(i == 6), 1'($urandom_range(0, 1)), rnd_op(), rnd_op(), 0, '0, '0);
    seq_idle();

    // Random mixed traffic with occasional restarts (with and without a sample).
    for (int i = 0; i < 30; i++)
      drive_seq(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 9) == 0),
                1'($urandom_range(0, 1)), rnd_op(), rnd_op(), 0, '0, '0);
    seq_idle();
    drain();

    // Reset with three samples in flight and out_valid high.
    for (int i = 0; i < 9; i++)
      drive_seq(1, 0, 1'($urandom_range(0, 1)), rnd_op(), rnd_op(), 0, '0, '0);
    seq_idle();
    seq_idle();
    seq_idle();
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check_eq("midrst_valid", 64'(s_out_valid), 64'(0));
    check_eq("midrst_x", 64'(s_x_out), 64'(0));
    check_eq("midrst_y", 64'(s_y_out), 64'(0));
    s_exp_x.delete(); s_exp_y.delete(); s_exp_t.delete();
    d_exp_x.delete(); d_exp_y.delete(); d_exp_t.delete();
    s_pre = 0; s_idx = 0; s_rep = 0;
    d_pre = 0; d_idx = 0; d_rep = 0;
    s_last_x = '0; s_last_y = '0; d_last_x = '0; d_last_y = '0;
    @(negedge clk);
    check_eq("rst_held_valid", 64'(s_out_valid), 64'(0));
    #2 rst = 1'b1;

    // Post-reset: idle long enough to expose stale results, then fresh samples.
    repeat (LAT + 2) seq_idle();
    drive_seq(1, 0, 0, 28'd0, 28'd1, 1, 28'd1, QM1);
    for (int i = 0; i < 6; i++)
      drive_seq(1, 0, 1'($urandom_range(0, 1)), rnd_op(), rnd_op(), 0, '0, '0);
    seq_idle();
    drain();

    check_eq("dir_queue_empty", 64'(d_exp_t.size()), 64'(0));
    check_eq("seq_queue_empty", 64'(s_exp_t.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
